// File: rtl/ds_stream_scheduler.sv
// Job sequencer for a streaming kernel: gates the weight, input and output
// valid/ready handshakes through weight-load and batch phases.
module ds_stream_scheduler #(
    parameter int W_BEATS   = 64,
    parameter int IN_BEATS  = 32,
    parameter int OUT_BEATS = 32,
    parameter int CNT_W     = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_num_batches,
    input  logic             cfg_reload_weights,
    output logic             stat_busy,
    output logic             stat_done,
    output logic             stat_err,
    output logic [CNT_W-1:0] stat_batch_cnt,
    input  logic             s_w_tvalid,
    output logic             s_w_tready,
    output logic             k_w_tvalid,
    input  logic             k_w_tready,
    input  logic             s_in_tvalid,
    output logic             s_in_tready,
    output logic             k_in_tvalid,
    input  logic             k_in_tready,
    input  logic             k_out_tvalid,
    output logic             k_out_tready,
    output logic             m_out_tvalid,
    input  logic             m_out_tready
);

    localparam int WW = $clog2(W_BEATS + 1);
    localparam int IW = $clog2(IN_BEATS + 1);
    localparam int OW = $clog2(OUT_BEATS + 1);

    localparam logic [WW-1:0] W_LAST   = WW'(W_BEATS - 1);
    localparam logic [IW-1:0] IN_MAX   = IW'(IN_BEATS);
    localparam logic [IW-1:0] IN_LAST  = IW'(IN_BEATS - 1);
    localparam logic [OW-1:0] OUT_MAX  = OW'(OUT_BEATS);
    localparam logic [OW-1:0] OUT_LAST = OW'(OUT_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WW-1:0]    w_cnt;
    logic [IW-1:0]    in_cnt;
    logic [OW-1:0]    out_cnt;
    logic [CNT_W-1:0] batch_cnt;
    logic [CNT_W-1:0] num_batches_q;
    logic [CNT_W-1:0] batch_inc;
    logic             w_loaded;
    logic             err_q;

    logic gate_w, gate_in, gate_out;
    logic w_beat, in_beat, out_beat;
    logic w_last_beat, in_full, out_full, batch_end;
    logic start_ok, start_bad;

    // Gate enables depend only on registered state, so no ready->ready paths.
    assign gate_w   = !ap_rst && (state == LOAD_W);
    assign gate_in  = !ap_rst && (state == RUN) && (in_cnt < IN_MAX);
    assign gate_out = !ap_rst && (state == RUN) && (out_cnt < OUT_MAX);

    assign k_w_tvalid   = s_w_tvalid & gate_w;
    assign s_w_tready   = k_w_tready & gate_w;
    assign k_in_tvalid  = s_in_tvalid & gate_in;
    assign s_in_tready  = k_in_tready & gate_in;
    assign m_out_tvalid = k_out_tvalid & gate_out;
    assign k_out_tready = m_out_tready & gate_out;

    assign w_beat   = s_w_tvalid & k_w_tready & gate_w;
    assign in_beat  = s_in_tvalid & k_in_tready & gate_in;
    assign out_beat = k_out_tvalid & m_out_tready & gate_out;

    assign w_last_beat = w_beat && (w_cnt == W_LAST);
    assign in_full     = (in_cnt == IN_MAX) || (in_beat && in_cnt == IN_LAST);
    assign out_full    = (out_cnt == OUT_MAX) || (out_beat && out_cnt == OUT_LAST);
    assign batch_end   = (state == RUN) && in_full && out_full;
    assign batch_inc   = batch_cnt + CNT_W'(1);

    assign start_ok  = (state == IDLE) && cfg_start && (cfg_num_batches != '0);
    assign start_bad = (state == IDLE) && cfg_start && (cfg_num_batches == '0);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = (cfg_reload_weights || !w_loaded) ? LOAD_W : RUN;
                end
            end
            LOAD_W: begin
                if (w_last_beat) state_nxt = RUN;
            end
            RUN: begin
                if (batch_end && batch_inc == num_batches_q) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state         <= IDLE;
            w_cnt         <= '0;
            in_cnt        <= '0;
            out_cnt       <= '0;
            batch_cnt     <= '0;
            num_batches_q <= '0;
            w_loaded      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= start_bad;
            if (start_ok) begin
                num_batches_q <= cfg_num_batches;
                batch_cnt     <= '0;
                in_cnt        <= '0;
                out_cnt       <= '0;
            end
            if (w_beat) begin
                if (w_last_beat) begin
                    w_cnt    <= '0;
                    w_loaded <= 1'b1;
                end else begin
                    w_cnt <= w_cnt + WW'(1);
                end
            end
            if (batch_end) begin
                in_cnt    <= '0;
                out_cnt   <= '0;
                batch_cnt <= batch_inc;
            end else begin
                if (in_beat) in_cnt <= in_cnt + IW'(1);
                if (out_beat) out_cnt <= out_cnt + OW'(1);
            end
        end
    end

    // Status is forced to its reset value while reset is asserted.
    assign stat_busy      = !ap_rst && (state == LOAD_W || state == RUN);
    assign stat_done      = !ap_rst && (state == DONE);
    assign stat_err       = !ap_rst && err_q;
    assign stat_batch_cnt = ap_rst ? '0 : batch_cnt;

endmodule

// File: tb/tb_ds_stream_scheduler.sv
// Randomized bench for ds_stream_scheduler against a job-level model
// tracking remaining beats and batches.
module tb_ds_stream_scheduler;

    localparam int W  = 64;
    localparam int IN = 32;
    localparam int OT = 32;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_num_batches = '0;
    logic        cfg_reload_weights = 1'b0;
    logic        stat_busy, stat_done, stat_err;
    logic [15:0] stat_batch_cnt;
    logic        s_w_tvalid = 1'b0, s_w_tready, k_w_tvalid, k_w_tready = 1'b0;
    logic        s_in_tvalid = 1'b0, s_in_tready, k_in_tvalid, k_in_tready = 1'b0;
    logic        k_out_tvalid = 1'b0, k_out_tready, m_out_tvalid, m_out_tready = 1'b0;

    ds_stream_scheduler dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .cfg_start(cfg_start), .cfg_num_batches(cfg_num_batches),
        .cfg_reload_weights(cfg_reload_weights),
        .stat_busy(stat_busy), .stat_done(stat_done), .stat_err(stat_err),
        .stat_batch_cnt(stat_batch_cnt),
        .s_w_tvalid(s_w_tvalid), .s_w_tready(s_w_tready),
        .k_w_tvalid(k_w_tvalid), .k_w_tready(k_w_tready),
        .s_in_tvalid(s_in_tvalid), .s_in_tready(s_in_tready),
        .k_in_tvalid(k_in_tvalid), .k_in_tready(k_in_tready),
        .k_out_tvalid(k_out_tvalid), .k_out_tready(k_out_tready),
        .m_out_tvalid(m_out_tvalid), .m_out_tready(m_out_tready)
    );

    always #5 ap_clk = ~ap_clk;

    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DONE = 3;

    int phase = P_IDLE;
    int w_left, in_left, out_left;
    int batches_done = 0, target = 0;
    bit resident = 0, err_pend = 0;

    int vectors = 0, miscompares = 0, cyc = 0;
    int p_v = 100, p_r = 100;
    int job_w, job_in, job_out, job_done, job_err;
    int last_w_cyc, first_in_cyc;
    bit obs_kin;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic cycle(input bit st, input int nb, input bit rl, input bit rs);
        bit gw, gi, go, wb, ib, ob;
        @(negedge ap_clk);
        ap_rst             = rs;
        cfg_start          = st;
        cfg_num_batches    = 16'(nb);
        cfg_reload_weights = rl;
        s_w_tvalid   = ($urandom_range(99) < p_v);
        s_in_tvalid  = ($urandom_range(99) < p_v);
        k_out_tvalid = ($urandom_range(99) < p_v);
        k_w_tready   = ($urandom_range(99) < p_r);
        k_in_tready  = ($urandom_range(99) < p_r);
        m_out_tready = ($urandom_range(99) < p_r);
        #1;
        gw = !rs && phase == P_LOAD;
        gi = !rs && phase == P_RUN && in_left > 0;
        go = !rs && phase == P_RUN && out_left > 0;
        chk("k_w_tvalid", k_w_tvalid, s_w_tvalid & gw);
        chk("s_w_tready", s_w_tready, k_w_tready & gw);
        chk("k_in_tvalid", k_in_tvalid, s_in_tvalid & gi);
        chk("s_in_tready", s_in_tready, k_in_tready & gi);
        chk("m_out_tvalid", m_out_tvalid, k_out_tvalid & go);
        chk("k_out_tready", k_out_tready, m_out_tready & go);
        chk("stat_busy", stat_busy, !rs && (phase == P_LOAD || phase == P_RUN));
        chk("stat_done", stat_done, !rs && phase == P_DONE);
        chk("stat_err", stat_err, !rs && err_pend);
        chk("stat_batch_cnt", stat_batch_cnt, rs ? 0 : batches_done);
        obs_kin = k_in_tvalid;
        wb = gw && s_w_tvalid && k_w_tready;
        ib = gi && s_in_tvalid && k_in_tready;
        ob = go && k_out_tvalid && m_out_tready;
        if (!rs && phase == P_DONE) job_done++;
        if (!rs && err_pend) job_err++;
        if (wb) begin job_w++; last_w_cyc = cyc; end
        if (ib) begin
            job_in++;
            if (first_in_cyc < 0) first_in_cyc = cyc;
        end
        if (ob) job_out++;
        if (rs) begin
            phase = P_IDLE; resident = 0; err_pend = 0;
            batches_done = 0; target = 0;
        end else begin
            err_pend = 0;
            case (phase)
                P_IDLE: if (st) begin
                    if (nb == 0) err_pend = 1;
                    else begin
                        target = nb; batches_done = 0;
                        in_left = IN; out_left = OT; w_left = W;
                        phase = (rl || !resident) ? P_LOAD : P_RUN;
                    end
                end
                P_LOAD: if (wb) begin
                    w_left--;
                    if (w_left == 0) begin resident = 1; phase = P_RUN; end
                end
                P_RUN: begin
                    if (ib) in_left--;
                    if (ob) out_left--;
                    if (in_left == 0 && out_left == 0) begin
                        batches_done++;
                        in_left = IN; out_left = OT;
                        if (batches_done == target) phase = P_DONE;
                    end
                end
                default: phase = P_IDLE;
            endcase
        end
        cyc++;
    endtask

    task automatic clr_stats();
        job_w = 0; job_in = 0; job_out = 0; job_done = 0; job_err = 0;
        last_w_cyc = -1; first_in_cyc = -1;
    endtask

    task automatic start_job(input int nb, input bit rl);
        clr_stats();
        cycle(1'b1, nb, rl, 1'b0);
    endtask

    // Runs until the model returns to idle; optionally pulses ignored starts.
    task automatic wait_idle(input int noise);
        int n = 0;
        while (phase != P_IDLE && n < 6000) begin
            cycle(($urandom_range(99) < noise) && phase != P_IDLE,
                  $urandom_range(3), $urandom_range(1), 1'b0);
            n++;
        end
        if (n >= 6000) begin
            miscompares++;
            $display("FAIL timeout waiting for idle cyc=%0d", cyc);
        end
    endtask

    initial begin
        clr_stats();
        repeat (3) cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("reset_busy", stat_busy, 0);
        chk("reset_batch_cnt", stat_batch_cnt, 0);

        p_v = 100; p_r = 100;
        start_job(2, 1'b0);
        wait_idle(0);
        chk("job1_w_beats", job_w, 64);
        chk("job1_in_beats", job_in, 64);
        chk("job1_out_beats", job_out, 64);
        chk("job1_done_pulses", job_done, 1);
        chk("job1_batch_cnt", stat_batch_cnt, 2);

        start_job(1, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("job2_run_next_cycle", obs_kin, 1);
        wait_idle(0);
        chk("job2_w_beats", job_w, 0);
        chk("job2_in_beats", job_in, 32);
        chk("job2_batch_cnt", stat_batch_cnt, 1);

        start_job(1, 1'b1);
        wait_idle(0);
        chk("job3_w_beats", job_w, 64);
        chk("job3_w_before_in", first_in_cyc > last_w_cyc, 1);

        clr_stats();
        cycle(1'b1, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("err_pulses", job_err, 1);
        chk("err_busy", stat_busy, 0);

        p_v = 70; p_r = 55;
        for (int j = 0; j < 6; j++) begin
            int nb = $urandom_range(1, 3);
            start_job(nb, $urandom_range(1));
            wait_idle(8);
            chk("rand_in_beats", job_in, nb * IN);
            chk("rand_out_beats", job_out, nb * OT);
            chk("rand_done_pulses", job_done, 1);
            chk("rand_batch_cnt", stat_batch_cnt, nb);
            repeat ($urandom_range(2)) cycle(1'b0, 0, 1'b0, 1'b0);
        end

        p_v = 100; p_r = 100;
        start_job(1, 1'b1);
        while (job_w < 10) cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("rst_mid_busy", stat_busy, 0);
        start_job(1, 1'b0);
        wait_idle(0);
        chk("rst_reload_w_beats", job_w, 64);
        chk("rst_reload_done", job_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
